// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues req/ack reads to instruction
// memory and presents each fetched word with its PC over valid/ready.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (reject misaligned redirects).
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [31:0]     i_imem_rdata,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pcplus4,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_misalign
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] drop_addr;    // address of the request that is still outstanding but doomed
  logic            drop_pending;
  logic            redir_take;
  logic            redir_bad;
  logic [XLEN-1:0] redir_tgt;

`ifdef FETCH_ALIGN_CHECK_EN
  assign redir_bad  = i_redirect && (i_redirect_pc[1:0] != 2'b00);
  assign redir_take = i_redirect && !redir_bad;
  assign redir_tgt  = i_redirect_pc;

  // One-cycle flag following a rejected (misaligned) redirect
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_misalign <= 1'b0;
    else       o_misalign <= redir_bad;
  end
`else
  // Misaligned targets are silently word-aligned instead of rejected
  assign redir_bad  = 1'b0;
  assign redir_take = i_redirect;
  assign redir_tgt  = i_redirect_pc & ~XLEN'(3);
  assign o_misalign = redir_bad;
`endif

  // Request is live for the whole FETCH state; the address of a request that
  // was overtaken by a redirect is held until its ack drains it.
  assign o_imem_req  = (state == FETCH);
  assign o_imem_addr = drop_pending ? drop_addr : pc;

  // Fetch FSM, PC and registered instruction outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      drop_addr    <= RESET_PC;
      drop_pending <= 1'b0;
      o_valid      <= 1'b0;
      o_instr      <= NOP;
      o_pc         <= RESET_PC;
      o_pcplus4    <= RESET_PC + XLEN'(4);
    end else begin
      case (state)
        BOOT: begin
          state <= FETCH;
          if (redir_take) pc <= redir_tgt;
        end
        FETCH: begin
          if (i_imem_ack) begin
            if (drop_pending || redir_take) begin
              // stale or overtaken data: discard and refetch from pc
              drop_pending <= 1'b0;
              if (redir_take) pc <= redir_tgt;
            end else begin
              o_instr   <= i_imem_rdata;
              o_pc      <= pc;
              o_pcplus4 <= pc + XLEN'(4);
              o_valid   <= 1'b1;
              pc        <= pc + XLEN'(4);
              state     <= HOLD;
            end
          end else if (redir_take) begin
            // keep the bus address stable; remember it only for the first redirect
            if (!drop_pending) drop_addr <= pc;
            drop_pending <= 1'b1;
            pc           <= redir_tgt;
          end
        end
        HOLD: begin
          if (redir_take) begin
            o_valid <= 1'b0;
            pc      <= redir_tgt;
            state   <= FETCH;
          end else if (i_ready) begin
            o_valid <= 1'b0;
            state   <= FETCH;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: one DUT with RESET_PC=0 and a second
// with RESET_PC=0xFFFF_FFFC for wrap and mid-fetch reset.
module tb_instr_fetch_unit;

  logic        clk;
  int          total = 0;
  int          bad   = 0;
  int          hs    = 0;

  // DUT a
  logic        a_rst, a_ack, a_ready, a_redir;
  logic [31:0] a_rdata, a_redir_pc;
  logic        a_req, a_valid, a_mis;
  logic [31:0] a_addr, a_instr, a_pc, a_pc4;

  // DUT b
  logic        b_rst, b_ack, b_ready, b_redir;
  logic [31:0] b_rdata, b_redir_pc;
  logic        b_req, b_valid, b_mis;
  logic [31:0] b_addr, b_instr, b_pc, b_pc4;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut_a (
    .i_clk(clk), .i_rst(a_rst), .o_imem_req(a_req), .o_imem_addr(a_addr),
    .i_imem_ack(a_ack), .i_imem_rdata(a_rdata), .o_valid(a_valid), .i_ready(a_ready),
    .o_instr(a_instr), .o_pc(a_pc), .o_pcplus4(a_pc4), .i_redirect(a_redir),
    .i_redirect_pc(a_redir_pc), .o_misalign(a_mis));

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_b (
    .i_clk(clk), .i_rst(b_rst), .o_imem_req(b_req), .o_imem_addr(b_addr),
    .i_imem_ack(b_ack), .i_imem_rdata(b_rdata), .o_valid(b_valid), .i_ready(b_ready),
    .o_instr(b_instr), .o_pc(b_pc), .o_pcplus4(b_pc4), .i_redirect(b_redir),
    .i_redirect_pc(b_redir_pc), .o_misalign(b_mis));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshakes on DUT a
  always @(posedge clk) if (!a_rst && a_valid && a_ready) hs <= hs + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, act, exp);
    end
  endtask

  initial begin
    a_rst = 1; a_ack = 0; a_ready = 0; a_redir = 0; a_rdata = 0; a_redir_pc = 0;
    b_rst = 1; b_ack = 0; b_ready = 0; b_redir = 0; b_rdata = 0; b_redir_pc = 0;
    tick();
    // reset state
    chk("rst_valid", {31'b0, a_valid}, 0);
    chk("rst_req",   {31'b0, a_req}, 0);
    chk("rst_instr", a_instr, 32'h0000_0013);
    chk("rst_pc",    a_pc, 32'h0);
    chk("rst_pc4",   a_pc4, 32'h4);
    chk("rst_mis",   {31'b0, a_mis}, 0);
    tick();
    a_rst = 0;
    tick();                                   // BOOT -> FETCH
    chk("t1_req",  {31'b0, a_req}, 1);
    chk("t1_addr", a_addr, 32'h0);
    a_ack = 1; a_rdata = 32'h0050_0093;
    tick();
    a_ack = 0;
    chk("t1_valid", {31'b0, a_valid}, 1);
    chk("t1_instr", a_instr, 32'h0050_0093);
    chk("t1_pc",    a_pc, 32'h0);
    chk("t1_pc4",   a_pc4, 32'h4);
    chk("t1_hreq",  {31'b0, a_req}, 0);
    a_ready = 1;
    tick();
    a_ready = 0;
    chk("t1_vdrop", {31'b0, a_valid}, 0);
    chk("t1_next",  a_addr, 32'h4);
    chk("t1_nreq",  {31'b0, a_req}, 1);

    // 2: backpressure
    a_ack = 1; a_rdata = 32'h00A0_0113;
    tick();
    a_ack = 1; a_rdata = 32'hBAD0_BAD0;       // ack outside FETCH must be ignored
    tick();
    a_ack = 0;
    tick();
    tick();
    chk("t2_valid", {31'b0, a_valid}, 1);
    chk("t2_instr", a_instr, 32'h00A0_0113);
    chk("t2_pc",    a_pc, 32'h4);
    chk("t2_pc4",   a_pc4, 32'h8);
    chk("t2_req",   {31'b0, a_req}, 0);
    chk("t2_hs0",   hs, 1);
    a_ready = 1;
    tick();
    a_ready = 0;
    chk("t2_hs",   hs, 2);
    chk("t2_next", a_addr, 32'h8);

    // 3: redirect in HOLD with ready
    a_ack = 1; a_rdata = 32'h0000_0033;
    tick();
    a_ack = 0;
    chk("t3_pc", a_pc, 32'h8);
    a_ready = 1; a_redir = 1; a_redir_pc = 32'h100;
    tick();
    a_ready = 0; a_redir = 0;
    chk("t3_valid", {31'b0, a_valid}, 0);
    chk("t3_addr",  a_addr, 32'h100);
    chk("t3_req",   {31'b0, a_req}, 1);
    tick();
    chk("t3_hs", hs, 3);

    // redirect coinciding with ack: data dropped, next request at target
    a_ack = 1; a_rdata = 32'h1111_1111; a_redir = 1; a_redir_pc = 32'h4;
    tick();
    a_ack = 0; a_redir = 0;
    chk("ra_valid", {31'b0, a_valid}, 0);
    chk("ra_addr",  a_addr, 32'h4);

    // 4: redirect while request at 0x4 waits for a late ack
    a_redir = 1; a_redir_pc = 32'h200;
    tick();
    a_redir = 0;
    chk("t4_hold_addr", a_addr, 32'h4);
    tick();
    a_ack = 1; a_rdata = 32'hDEAD_BEEF;
    tick();
    a_ack = 0;
    chk("t4_drop", {31'b0, a_valid}, 0);
    chk("t4_addr", a_addr, 32'h200);
    a_ack = 1; a_rdata = 32'h1234_5678;
    tick();
    a_ack = 0;
    chk("t4_valid", {31'b0, a_valid}, 1);
    chk("t4_instr", a_instr, 32'h1234_5678);
    chk("t4_pc",    a_pc, 32'h200);
    chk("t4_pc4",   a_pc4, 32'h204);
    a_ready = 1;
    tick();
    a_ready = 0;
    chk("t4_next", a_addr, 32'h204);

    // 6: misaligned redirect while fetching 0x204
    a_redir = 1; a_redir_pc = 32'h102;
    tick();
    a_redir = 0;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("t6_mis1", {31'b0, a_mis}, 1);
    chk("t6_addr", a_addr, 32'h204);
    tick();
    chk("t6_mis0", {31'b0, a_mis}, 0);
    a_ack = 1; a_rdata = 32'h0000_0013;
    tick();
    a_ack = 0;
    chk("t6_valid", {31'b0, a_valid}, 1);
    chk("t6_pc",    a_pc, 32'h204);
`else
    chk("t6_mis1", {31'b0, a_mis}, 0);
    chk("t6_hold", a_addr, 32'h204);
    tick();
    chk("t6_mis0", {31'b0, a_mis}, 0);
    a_ack = 1; a_rdata = 32'h0000_0013;
    tick();
    a_ack = 0;
    chk("t6_valid", {31'b0, a_valid}, 0);
    chk("t6_addr",  a_addr, 32'h100);
`endif

    // 5: wrap and mid-fetch reset on DUT b
    chk("t5_rpc4", b_pc4, 32'h0);
    b_rst = 0;
    tick();
    chk("t5_addr0", b_addr, 32'hFFFF_FFFC);
    b_ack = 1; b_rdata = 32'h0000_0013;
    tick();
    b_ack = 0;
    chk("t5_pc",  b_pc, 32'hFFFF_FFFC);
    chk("t5_pc4", b_pc4, 32'h0);
    b_ready = 1;
    tick();
    b_ready = 0;
    chk("t5_addr1", b_addr, 32'h0);
    chk("t5_req1",  {31'b0, b_req}, 1);
    b_rst = 1;
    #1;
    chk("t5_rreq", {31'b0, b_req}, 0);
    chk("t5_rval", {31'b0, b_valid}, 0);
    b_ack = 1; b_rdata = 32'hCAFE_F00D;
    tick();
    b_rst = 0;
    tick();                                   // late ack during BOOT is ignored
    b_ack = 0;
    chk("t5_late_val",   {31'b0, b_valid}, 0);
    chk("t5_late_instr", b_instr, 32'h0000_0013);
    chk("t5_late_addr",  b_addr, 32'hFFFF_FFFC);
    chk("t5_late_req",   {31'b0, b_req}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
